pipe_ctrl: RTL and testbench

Pipeline control unit for the five-stage core. Generates the per-stage stall and flush signals that gate the IF/ID, ID/EX, EX/MEM and MEM/WB pipeline registers, and the `int_detect` strobe consumed by the EX/MEM register. Commits exceptions and exception returns at the MEM stage. Owns the control-register file (status, interrupt mask, exception code, EPC, vector).

---
 rtl/pipe_ctrl.sv | 140 ++++++++++++++
 tb/tb_pipe_ctrl.sv | 212 +++++++++++++++++++++
 2 files changed

// File: rtl/pipe_ctrl.sv
// pipe_ctrl: pipeline control unit for the five-stage core.
//   Produces the per-stage stall/flush controls and the redirect target.
//   Commits exceptions and exception returns in MEM.
//   Holds the control-register file and the external-interrupt detector.
// Ports:
//   clk, reset          clock; asynchronous active-high reset
//   if_busy, mem_busy   memory-side not-ready inputs (global stall)
//   ld_hazard           load-use hazard seen in ID
//   mem_pc/mem_en/mem_ctrl_op/mem_exp_code  MEM-stage instruction info
//   creg_wr_addr/data   WRCR target and data
//   creg_rd_addr/data   combinational control-register read port
//   irq[7:0]            asynchronous level-sensitive interrupt lines
//   *_stall, *_flush    per-stage register hold / bubble
//   new_pc              redirect target, meaningful while if_flush=1
//   int_detect          unmasked interrupt pending while int_en=1
module pipe_ctrl #(
  parameter logic [31:0] EXP_VECTOR = 32'h0000_0100
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        if_busy,
  input  logic        mem_busy,
  input  logic        ld_hazard,
  input  logic [31:0] mem_pc,
  input  logic        mem_en,
  input  logic [1:0]  mem_ctrl_op,
  input  logic [2:0]  mem_exp_code,
  input  logic [4:0]  creg_wr_addr,
  input  logic [31:0] creg_wr_data,
  input  logic [4:0]  creg_rd_addr,
  output logic [31:0] creg_rd_data,
  input  logic [7:0]  irq,
  output logic        if_stall,
  output logic        id_stall,
  output logic        ex_stall,
  output logic        mem_stall,
  output logic        if_flush,
  output logic        id_flush,
  output logic        ex_flush,
  output logic        mem_flush,
  output logic [31:0] new_pc,
  output logic        int_detect
);

  localparam logic [1:0] OP_WRCR = 2'd1;
  localparam logic [1:0] OP_EXRT = 2'd2;

  localparam logic [4:0] A_STATUS = 5'd0;
  localparam logic [4:0] A_MASK   = 5'd1;
  localparam logic [4:0] A_CODE   = 5'd2;
  localparam logic [4:0] A_EPC    = 5'd3;
  localparam logic [4:0] A_VECTOR = 5'd4;

  logic        r_int_en, r_pre_int_en;
  logic [7:0]  r_int_mask;
  logic [2:0]  r_exp_code;
  logic [31:0] r_epc, r_vector;
  logic [7:0]  r_irq_m, r_irq_s;

  logic w_stall, w_commit, w_exp, w_exrt, w_wrcr, w_flush;

  assign w_stall  = if_busy | mem_busy;
  // Commit happens only for a valid, non-stalled MEM instruction; an
  // exception outranks EXRT, which outranks WRCR.
  assign w_commit = ~reset & ~w_stall & mem_en;
  assign w_exp    = w_commit & (mem_exp_code != 3'd0);
  assign w_exrt   = w_commit & (mem_exp_code == 3'd0) & (mem_ctrl_op == OP_EXRT);
  assign w_wrcr   = w_commit & (mem_exp_code == 3'd0) & (mem_ctrl_op == OP_WRCR);
  assign w_flush  = w_exp | w_exrt;

  assign if_stall  = ~reset & (w_stall | ld_hazard);
  assign id_stall  = ~reset & w_stall;
  assign ex_stall  = ~reset & w_stall;
  assign mem_stall = ~reset & w_stall;

  assign if_flush  = w_flush;
  // A load-use hazard bubbles ID while IF holds, unless the whole pipe is stalled.
  assign id_flush  = w_flush | (~reset & ld_hazard & ~w_stall);
  assign ex_flush  = w_flush;
  assign mem_flush = w_flush;

  assign new_pc = w_exp ? r_vector : (w_exrt ? r_epc : 32'd0);

  assign int_detect = ~reset & r_int_en & (|(r_irq_s & ~r_int_mask));

  // Read port has no bypass: a same-cycle write is seen next cycle.
  always_comb begin
    creg_rd_data = 32'd0;
    if (!reset) begin
      case (creg_rd_addr)
        A_STATUS: creg_rd_data = {30'd0, r_pre_int_en, r_int_en};
        A_MASK:   creg_rd_data = {24'd0, r_int_mask};
        A_CODE:   creg_rd_data = {29'd0, r_exp_code};
        A_EPC:    creg_rd_data = r_epc;
        A_VECTOR: creg_rd_data = r_vector;
        default:  creg_rd_data = 32'd0;
      endcase
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_irq_m <= 8'd0;
      r_irq_s <= 8'd0;
    end else begin
      r_irq_m <= irq;
      r_irq_s <= r_irq_m;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_int_en     <= 1'b0;
      r_pre_int_en <= 1'b0;
      r_int_mask   <= 8'hFF;
      r_exp_code   <= 3'd0;
      r_epc        <= 32'd0;
      r_vector     <= EXP_VECTOR;
    end else if (w_exp) begin
      r_epc        <= mem_pc;
      r_exp_code   <= mem_exp_code;
      r_pre_int_en <= r_int_en;
      r_int_en     <= 1'b0;
    end else if (w_exrt) begin
      r_int_en     <= r_pre_int_en;
    end else if (w_wrcr) begin
      case (creg_wr_addr)
        A_STATUS: begin
          r_int_en     <= creg_wr_data[0];
          r_pre_int_en <= creg_wr_data[1];
        end
        A_MASK:   r_int_mask <= creg_wr_data[7:0];
        A_EPC:    r_epc      <= creg_wr_data;
        A_VECTOR: r_vector   <= creg_wr_data;
        default:  ;
      endcase
    end
  end

endmodule

// File: tb/tb_pipe_ctrl.sv
// Directed bench for pipe_ctrl: hand-computed expectations checked with
// immediate assertions along one linear stimulus sequence.
module tb_pipe_ctrl;

  logic        clk = 1'b0;
  logic        reset;
  logic        if_busy, mem_busy, ld_hazard;
  logic [31:0] mem_pc;
  logic        mem_en;
  logic [1:0]  mem_ctrl_op;
  logic [2:0]  mem_exp_code;
  logic [4:0]  creg_wr_addr, creg_rd_addr;
  logic [31:0] creg_wr_data, creg_rd_data;
  logic [7:0]  irq;
  logic        if_stall, id_stall, ex_stall, mem_stall;
  logic        if_flush, id_flush, ex_flush, mem_flush;
  logic [31:0] new_pc;
  logic        int_detect;

  int n_vec = 0;
  int n_err = 0;

  pipe_ctrl dut (
    .clk(clk), .reset(reset),
    .if_busy(if_busy), .mem_busy(mem_busy), .ld_hazard(ld_hazard),
    .mem_pc(mem_pc), .mem_en(mem_en), .mem_ctrl_op(mem_ctrl_op),
    .mem_exp_code(mem_exp_code),
    .creg_wr_addr(creg_wr_addr), .creg_wr_data(creg_wr_data),
    .creg_rd_addr(creg_rd_addr), .creg_rd_data(creg_rd_data),
    .irq(irq),
    .if_stall(if_stall), .id_stall(id_stall), .ex_stall(ex_stall), .mem_stall(mem_stall),
    .if_flush(if_flush), .id_flush(id_flush), .ex_flush(ex_flush), .mem_flush(mem_flush),
    .new_pc(new_pc), .int_detect(int_detect)
  );

  always #5 clk = ~clk;

  // {if,id,ex,mem}_stall then {if,id,ex,mem}_flush
  logic [7:0] ctl;
  assign ctl = {if_stall, id_stall, ex_stall, mem_stall,
                if_flush, id_flush, ex_flush, mem_flush};

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic rd(input string tag, input logic [4:0] a, input logic [31:0] exp);
    creg_rd_addr = a;
    #1;
    chk(tag, creg_rd_data, exp);
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic mem_idle();
    mem_en = 0; mem_ctrl_op = 0; mem_exp_code = 0;
  endtask

  task automatic wrcr(input logic [4:0] a, input logic [31:0] d);
    mem_en = 1; mem_ctrl_op = 2'd1; mem_exp_code = 0;
    creg_wr_addr = a; creg_wr_data = d;
  endtask

  initial begin
    reset = 1; if_busy = 0; mem_busy = 0; ld_hazard = 0;
    mem_pc = 0; mem_idle(); creg_wr_addr = 0; creg_wr_data = 0;
    creg_rd_addr = 5'd4; irq = 0;

    // Outputs held at 0 during reset, even with a hazard present.
    ld_hazard = 1;
    #2;
    chk("rst_ctl", {24'd0, ctl}, 32'h0);
    rd("rst_rd_vec", 5'd4, 32'h0);
    ld_hazard = 0;
    step(); step();
    reset = 0;
    #1;

    // Idle after reset
    chk("idle_ctl", {24'd0, ctl}, 32'h00);
    rd("idle_vector", 5'd4, 32'h100);
    rd("idle_mask", 5'd1, 32'hFF);
    rd("idle_status", 5'd0, 32'h0);
    chk("idle_intdet", {31'd0, int_detect}, 32'd0);

    // Load-use hazard: IF holds, ID bubbles
    step();
    ld_hazard = 1; #1;
    chk("ldh_ctl", {24'd0, ctl}, 32'h84);
    mem_busy = 1; #1;
    chk("ldh_busy_ctl", {24'd0, ctl}, 32'hF0);
    ld_hazard = 0; mem_busy = 0;

    // WRCR STATUS=1; no same-cycle bypass
    step();
    wrcr(5'd0, 32'h1); #1;
    chk("wrcr_ctl", {24'd0, ctl}, 32'h00);
    rd("wrcr_nobypass", 5'd0, 32'h0);
    step();
    rd("wrcr_status", 5'd0, 32'h1);
    wrcr(5'd1, 32'hFFFF_FFFE);
    step();
    rd("wrcr_mask", 5'd1, 32'hFE);
    wrcr(5'd2, 32'h7);          // read-only
    step();
    rd("wrcr_ro_code", 5'd2, 32'h0);
    wrcr(5'd9, 32'h1234);       // undefined address
    step();
    rd("wrcr_undef", 5'd9, 32'h0);
    mem_idle();

    // irq[0] one-cycle pulse: visible two edges later, for one cycle
    irq = 8'h01;
    step();
    irq = 8'h00; #1;
    chk("irq0_after1", {31'd0, int_detect}, 32'd0);
    step();
    chk("irq0_after2", {31'd0, int_detect}, 32'd1);
    step();
    chk("irq0_after3", {31'd0, int_detect}, 32'd0);
    // irq[1] is masked
    irq = 8'h02;
    step(); step(); step();
    chk("irq1_masked", {31'd0, int_detect}, 32'd0);
    irq = 8'h00;
    step(); step();

    // Overflow exception at pc 0x40
    mem_en = 1; mem_pc = 32'h40; mem_exp_code = 3'd3; mem_ctrl_op = 0; #1;
    chk("exc_ctl", {24'd0, ctl}, 32'h0F);
    chk("exc_newpc", new_pc, 32'h100);
    step();
    mem_idle(); #1;
    chk("exc_idle_ctl", {24'd0, ctl}, 32'h00);
    rd("exc_epc", 5'd3, 32'h40);
    rd("exc_code", 5'd2, 32'h3);
    rd("exc_status", 5'd0, 32'h2);

    // EXRT held off by mem_busy
    mem_en = 1; mem_ctrl_op = 2'd2; mem_busy = 1; #1;
    chk("exrt_busy_ctl", {24'd0, ctl}, 32'hF0);
    chk("exrt_busy_newpc", new_pc, 32'h0);
    step();
    rd("exrt_busy_status", 5'd0, 32'h2);
    mem_busy = 0; #1;
    chk("exrt_ctl", {24'd0, ctl}, 32'h0F);
    chk("exrt_newpc", new_pc, 32'h40);
    step();
    mem_idle();
    rd("exrt_status", 5'd0, 32'h3);

    // Trap carrying a WRCR to EPC: write discarded, EPC = mem_pc
    mem_en = 1; mem_pc = 32'h80; mem_exp_code = 3'd5; mem_ctrl_op = 2'd1;
    creg_wr_addr = 5'd3; creg_wr_data = 32'hDEAD_BEEF; #1;
    chk("trapwr_newpc", new_pc, 32'h100);
    step();
    // Back-to-back EXRT uses the EPC written on the previous edge
    mem_exp_code = 0; mem_ctrl_op = 2'd2; #1;
    chk("b2b_newpc", new_pc, 32'h80);
    rd("trapwr_epc", 5'd3, 32'h80);
    rd("trapwr_code", 5'd2, 32'h5);
    rd("trapwr_status", 5'd0, 32'h2);
    step();
    mem_idle();
    rd("b2b_status", 5'd0, 32'h3);

    // External interrupt taken as code 1 drops int_detect next cycle
    irq = 8'h01;
    step(); step();
    chk("ext_intdet", {31'd0, int_detect}, 32'd1);
    mem_en = 1; mem_pc = 32'h200; mem_exp_code = 3'd1; #1;
    chk("ext_ctl", {24'd0, ctl}, 32'h0F);
    step();
    mem_idle(); #1;
    chk("ext_intdet_drop", {31'd0, int_detect}, 32'd0);
    rd("ext_code", 5'd2, 32'h1);
    rd("ext_epc", 5'd3, 32'h200);

    // Reprogram VECTOR, then reset mid-exception
    wrcr(5'd4, 32'h300);
    step();
    mem_idle();
    rd("vec_wr", 5'd4, 32'h300);
    mem_en = 1; mem_pc = 32'h44; mem_exp_code = 3'd2; #1;
    chk("pre_rst_newpc", new_pc, 32'h300);
    reset = 1; #1;
    chk("midrst_ctl", {24'd0, ctl}, 32'h00);
    chk("midrst_newpc", new_pc, 32'h0);
    step();
    mem_idle();
    reset = 0; #1;
    rd("post_rst_vector", 5'd4, 32'h100);
    rd("post_rst_mask", 5'd1, 32'hFF);
    rd("post_rst_epc", 5'd3, 32'h0);
    rd("post_rst_code", 5'd2, 32'h0);
    rd("post_rst_status", 5'd0, 32'h0);
    chk("post_rst_intdet", {31'd0, int_detect}, 32'd0);
    irq = 8'h00;
    step();

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
